// File: rtl/world_view_fetch_if.sv
// World RAM read port: the fetcher is master (strobe/address), the RAM is slave (data).
interface world_view_fetch_if #(
  parameter int ADDR_W = 8
);
  logic              mem_rd;
  logic [ADDR_W-1:0] mem_addr;
  logic [4:0]        mem_rdata;

  modport master (output mem_rd, output mem_addr, input mem_rdata);
  modport slave  (input mem_rd, input mem_addr, output mem_rdata);
endinterface

// File: rtl/world_view_fetch.sv
// Fetches an NDIG-cell window of the world RAM once per refresh tick and commits it
// atomically to the packed digit bus; button pulses scroll the viewport with saturation.
module world_view_fetch #(
  parameter int W_COLS      = 16,
  parameter int H_ROWS      = 16,
  parameter int NDIG        = 8,
  parameter int ADDR_W      = 8,
  parameter int REFRESH_DIV = 50000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 scroll_left,
  input  logic                 scroll_right,
  input  logic                 scroll_up,
  input  logic                 scroll_down,
  world_view_fetch_if.master   mem,
  output logic [5*NDIG-1:0]    cells,
  output logic                 frame_valid,
  output logic [ADDR_W-1:0]    view_x,
  output logic [ADDR_W-1:0]    view_y
);
  typedef enum logic [2:0] {S_IDLE, S_START, S_FETCH, S_DRAIN, S_COMMIT} state_t;
  typedef enum logic [1:0] {STEP_NONE, STEP_NEG, STEP_POS} step_t;

  localparam int DIV_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int CNT_W = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(REFRESH_DIV - 1);
  localparam logic [DIV_W-1:0]  DIV_ONE  = DIV_W'(1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(NDIG - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  localparam logic [ADDR_W-1:0] A_ONE    = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] X_MAX    = ADDR_W'(W_COLS - NDIG);
  localparam logic [ADDR_W-1:0] Y_MAX    = ADDR_W'(H_ROWS - 1);
  localparam logic [ADDR_W-1:0] PITCH    = ADDR_W'(W_COLS);

  state_t                 state_q, state_d;
  step_t                  dx_q, dx_d, dy_q, dy_d;
  logic [DIV_W-1:0]       div_q, div_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [CNT_W-1:0]       cap_idx;
  logic [ADDR_W-1:0]      addr_q, addr_d;
  logic [ADDR_W-1:0]      vx_q, vx_d, vy_q, vy_d;
  logic [NDIG-1:0][4:0]   shadow_q, shadow_d, cells_q, cells_d;
  logic                   fv_q, fv_d;
  logic                   tick;

  always_comb begin
    tick     = (div_q == DIV_LAST);
    div_d    = tick ? '0 : div_q + DIV_ONE;
    state_d  = state_q;
    cnt_d    = cnt_q;
    cap_idx  = cnt_q - CNT_ONE;
    addr_d   = addr_q;
    vx_d     = vx_q;
    vy_d     = vy_q;
    dx_d     = dx_q;
    dy_d     = dy_q;
    shadow_d = shadow_q;
    cells_d  = cells_q;
    fv_d     = 1'b0;

    unique case (state_q)
      S_IDLE: if (tick) state_d = S_START;
      S_START: begin
        unique case (dx_q)
          STEP_NEG: if (vx_q != '0)  vx_d = vx_q - A_ONE;
          STEP_POS: if (vx_q < X_MAX) vx_d = vx_q + A_ONE;
          default: ;
        endcase
        unique case (dy_q)
          STEP_NEG: if (vy_q != '0)  vy_d = vy_q - A_ONE;
          STEP_POS: if (vy_q < Y_MAX) vy_d = vy_q + A_ONE;
          default: ;
        endcase
        dx_d    = STEP_NONE;
        dy_d    = STEP_NONE;
        addr_d  = vy_d * PITCH + vx_d;
        cnt_d   = '0;
        state_d = S_FETCH;
      end
      S_FETCH: begin
        // read data lags the strobe by one cycle, so capture trails the address by one slot
        if (cnt_q != '0) shadow_d[cap_idx] = mem.mem_rdata;
        if (cnt_q == CNT_LAST) begin
          state_d = S_DRAIN;
        end else begin
          cnt_d  = cnt_q + CNT_ONE;
          addr_d = addr_q + A_ONE;
        end
      end
      S_DRAIN: begin
        shadow_d[NDIG-1] = mem.mem_rdata;
        state_d          = S_COMMIT;
      end
      S_COMMIT: begin
        cells_d = shadow_q;
        fv_d    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // a pulse in the START cycle is newer than the one just consumed, so it stays pending
    if (scroll_left ^ scroll_right) dx_d = scroll_right ? STEP_POS : STEP_NEG;
    if (scroll_up ^ scroll_down)    dy_d = scroll_down  ? STEP_POS : STEP_NEG;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      dx_q     <= STEP_NONE;
      dy_q     <= STEP_NONE;
      div_q    <= '0;
      cnt_q    <= '0;
      addr_q   <= '0;
      vx_q     <= '0;
      vy_q     <= '0;
      shadow_q <= '0;
      cells_q  <= '0;
      fv_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      dx_q     <= dx_d;
      dy_q     <= dy_d;
      div_q    <= div_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      vx_q     <= vx_d;
      vy_q     <= vy_d;
      shadow_q <= shadow_d;
      cells_q  <= cells_d;
      fv_q     <= fv_d;
    end
  end

  assign mem.mem_rd   = (state_q == S_FETCH);
  assign mem.mem_addr = addr_q;
  assign cells        = cells_q;
  assign frame_valid  = fv_q;
  assign view_x       = vx_q;
  assign view_y       = vy_q;
endmodule
